// File: rtl/serialtopar_aligner_pkg.sv
// Shared definitions for the serial receive path: the comma/idle byte agreed
// with the transmitter and the aligner state encoding.
package serialtopar_aligner_pkg;

    localparam logic [7:0] COMMA = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/serialtopar_aligner.sv
// Serial-to-parallel receiver: hunts the comma bit-by-bit, confirms byte
// alignment over LOCK_COMMAS boundaries, then rebuilds and flags data bytes.
module serialtopar_aligner #(
    parameter logic [7:0] COMMA       = serialtopar_aligner_pkg::COMMA,
    parameter int         LOCK_COMMAS = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);
    import serialtopar_aligner_pkg::*;

    localparam int            CW       = (LOCK_COMMAS < 2) ? 1 : $clog2(LOCK_COMMAS + 1);
    localparam logic [CW-1:0] LOCK_CNT = CW'(LOCK_COMMAS);

    state_t        state_reg, state_next;
    logic [7:0]    sr_reg;
    logic [7:0]    window;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [CW-1:0] comma_cnt_reg, comma_cnt_next;
    logic [7:0]    data_reg, data_next;
    logic          valid_reg, valid_next;
    logic          strobe_reg, strobe_next;
    logic          active_reg, active_next;
    logic          boundary;
    logic          is_comma;

    // The window includes the bit arriving this edge, so a byte completes
    // and is acted on at the same edge its LSB is sampled.
    assign window   = {sr_reg[6:0], serial_in};
    assign boundary = (bit_cnt_reg == 3'd7);
    assign is_comma = (window == COMMA);

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            sr_reg <= 8'h00;
        end else begin
            sr_reg <= window;
        end
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            bit_cnt_reg   <= 3'd0;
            comma_cnt_reg <= '0;
        end else begin
            bit_cnt_reg   <= bit_cnt_next;
            comma_cnt_reg <= comma_cnt_next;
        end
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state_reg  <= SEARCH;
            data_reg   <= 8'h00;
            valid_reg  <= 1'b0;
            strobe_reg <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            data_reg   <= data_next;
            valid_reg  <= valid_next;
            strobe_reg <= strobe_next;
            active_reg <= active_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg + 3'd1;
        comma_cnt_next = comma_cnt_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        strobe_next    = 1'b0;
        case (state_reg)
            SEARCH: begin
                bit_cnt_next = 3'd0;
                if (is_comma) begin
                    comma_cnt_next = CW'(1);
                    state_next     = (LOCK_COMMAS == 1) ? LOCKED : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (!is_comma) begin
                        // A rejected boundary byte is not re-tested as a fresh comma.
                        comma_cnt_next = '0;
                        state_next     = SEARCH;
                    end else if (comma_cnt_reg + CW'(1) == LOCK_CNT) begin
                        comma_cnt_next = LOCK_CNT;
                        state_next     = LOCKED;
                    end else begin
                        comma_cnt_next = comma_cnt_reg + CW'(1);
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    data_next   = window;
                    valid_next  = !is_comma;
                    strobe_next = 1'b1;
                end
            end
            default: begin
                state_next = SEARCH;
            end
        endcase
        active_next = (state_next == LOCKED);
    end

    assign data_out    = data_reg;
    assign valid_out   = valid_reg;
    assign byte_strobe = strobe_reg;
    assign active      = active_reg;

endmodule

// File: tb/tb_serialtopar_aligner.sv
// Bench for serialtopar_aligner: directed and random bitstreams compared
// every bit against a history-scanning reference, for LOCK_COMMAS=4 and 1.
module tb_serialtopar_aligner;

    logic       clk_8f = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b0;
    logic [7:0] data_out, data_out1;
    logic       valid_out, valid_out1;
    logic       byte_strobe, byte_strobe1;
    logic       active, active1;

    int checks = 0;
    int failures = 0;

    logic hist[$];
    logic stim[$];

    always #5 clk_8f = ~clk_8f;

    serialtopar_aligner #(.COMMA(8'hBC), .LOCK_COMMAS(4)) dut (
        .clk_8f(clk_8f), .reset(reset), .serial_in(serial_in),
        .data_out(data_out), .valid_out(valid_out),
        .byte_strobe(byte_strobe), .active(active)
    );

    serialtopar_aligner #(.COMMA(8'hBC), .LOCK_COMMAS(1)) dut1 (
        .clk_8f(clk_8f), .reset(reset), .serial_in(serial_in),
        .data_out(data_out1), .valid_out(valid_out1),
        .byte_strobe(byte_strobe1), .active(active1)
    );

    // Byte ending at history index t (bits before reset count as 0).
    function automatic logic [7:0] win(input int t);
        logic [7:0] w;
        w = 8'h00;
        for (int k = t - 7; k <= t; k++)
            w = {w[6:0], (k >= 0) ? hist[k] : 1'b0};
        return w;
    endfunction

    // Expected {active, byte_strobe, valid_out, data_out} after the latest bit:
    // find the first comma whose next lc-1 byte-spaced windows are all commas;
    // a failed run resumes the hunt one bit after the failing byte.
    function automatic logic [10:0] model(input int lc);
        int  n, t, u, lk, b;
        bit  ok;
        n  = hist.size();
        t  = 0;
        lk = -1;
        while (t < n && lk < 0) begin
            if (win(t) == 8'hBC) begin
                ok = 1'b1;
                u  = t;
                for (int c = 1; c < lc; c++) begin
                    u = u + 8;
                    if (u >= n) return 11'd0;
                    if (win(u) != 8'hBC) begin
                        ok = 1'b0;
                        break;
                    end
                end
                if (ok) lk = u;
                else t = u + 1;
            end else begin
                t = t + 1;
            end
        end
        if (lk < 0) return 11'd0;
        b = lk + ((n - 1 - lk) / 8) * 8;
        if (b == lk) return {1'b1, 10'd0};
        return {1'b1, (b == n - 1), (win(b) != 8'hBC), win(b)};
    endfunction

    task automatic drive_bit(input logic b);
        @(negedge clk_8f);
        serial_in = b;
        @(posedge clk_8f);
        hist.push_back(b);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_8f);
        reset = 1'b1;
        serial_in = 1'($urandom_range(1));
        @(posedge clk_8f);
        hist.delete();
        #1;
        reset = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int k = 7; k >= 0; k--) stim.push_back(v[k]);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({active, byte_strobe, valid_out, data_out} !== 11'd0) begin
            failures++;
            $display("FAIL reset_l4 got=%h exp=000", {active, byte_strobe, valid_out, data_out});
        end
        checks++;
        if ({active1, byte_strobe1, valid_out1, data_out1} !== 11'd0) begin
            failures++;
            $display("FAIL reset_l1 got=%h exp=000", {active1, byte_strobe1, valid_out1, data_out1});
        end
    endtask

    task automatic test_initial_lock();
        do_reset();
        stim.delete();
        for (int k = 0; k < 3; k++) stim.push_back(1'($urandom_range(1)));
        for (int k = 0; k < 4; k++) push_byte(8'hBC);
        for (int i = 0; i < stim.size(); i++) begin
            drive_bit(stim[i]);
            checks++;
            if ({active, byte_strobe, valid_out, data_out} !== model(4)) begin
                failures++;
                $display("FAIL initial_lock_l4 bit=%0d got=%h exp=%h", i, {active, byte_strobe, valid_out, data_out}, model(4));
            end
            checks++;
            if ({active1, byte_strobe1, valid_out1, data_out1} !== model(1)) begin
                failures++;
                $display("FAIL initial_lock_l1 bit=%0d got=%h exp=%h", i, {active1, byte_strobe1, valid_out1, data_out1}, model(1));
            end
        end
        checks++;
        if (active !== 1'b1 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL initial_lock_end active=%b valid=%b exp active=1 valid=0", active, valid_out);
        end
    endtask

    task automatic test_locked_data();
        stim.delete();
        push_byte(8'hA5); push_byte(8'h3C); push_byte(8'hBC); push_byte(8'hFF);
        for (int i = 0; i < stim.size(); i++) begin
            drive_bit(stim[i]);
            checks++;
            if ({active, byte_strobe, valid_out, data_out} !== model(4)) begin
                failures++;
                $display("FAIL locked_data_l4 bit=%0d got=%h exp=%h", i, {active, byte_strobe, valid_out, data_out}, model(4));
            end
            checks++;
            if ({active1, byte_strobe1, valid_out1, data_out1} !== model(1)) begin
                failures++;
                $display("FAIL locked_data_l1 bit=%0d got=%h exp=%h", i, {active1, byte_strobe1, valid_out1, data_out1}, model(1));
            end
        end
        checks++;
        if (data_out !== 8'hFF || valid_out !== 1'b1 || byte_strobe !== 1'b1) begin
            failures++;
            $display("FAIL locked_data_last data=%h v=%b s=%b exp data=ff v=1 s=1", data_out, valid_out, byte_strobe);
        end
    endtask

    task automatic test_align_abort();
        do_reset();
        stim.delete();
        push_byte(8'hBC); push_byte(8'hBC); push_byte(8'h11);
        for (int k = 0; k < 4; k++) push_byte(8'hBC);
        for (int i = 0; i < stim.size(); i++) begin
            drive_bit(stim[i]);
            checks++;
            if ({active, byte_strobe, valid_out, data_out} !== model(4)) begin
                failures++;
                $display("FAIL align_abort_l4 bit=%0d got=%h exp=%h", i, {active, byte_strobe, valid_out, data_out}, model(4));
            end
            checks++;
            if ({active1, byte_strobe1, valid_out1, data_out1} !== model(1)) begin
                failures++;
                $display("FAIL align_abort_l1 bit=%0d got=%h exp=%h", i, {active1, byte_strobe1, valid_out1, data_out1}, model(1));
            end
        end
        checks++;
        if (active !== 1'b1) begin
            failures++;
            $display("FAIL align_abort_relock active=%b exp=1", active);
        end
    endtask

    task automatic test_false_comma();
        do_reset();
        stim.delete();
        push_byte(8'h5E); push_byte(8'h3F);
        for (int k = 0; k < 4; k++) push_byte(8'hBC);
        for (int i = 0; i < stim.size(); i++) begin
            drive_bit(stim[i]);
            checks++;
            if ({active, byte_strobe, valid_out, data_out} !== model(4)) begin
                failures++;
                $display("FAIL false_comma_l4 bit=%0d got=%h exp=%h", i, {active, byte_strobe, valid_out, data_out}, model(4));
            end
            checks++;
            if ({active1, byte_strobe1, valid_out1, data_out1} !== model(1)) begin
                failures++;
                $display("FAIL false_comma_l1 bit=%0d got=%h exp=%h", i, {active1, byte_strobe1, valid_out1, data_out1}, model(1));
            end
        end
        checks++;
        if (active !== 1'b1) begin
            failures++;
            $display("FAIL false_comma_lock active=%b exp=1", active);
        end
    endtask

    task automatic test_midbyte_reset();
        do_reset();
        stim.delete();
        for (int k = 0; k < 4; k++) push_byte(8'hBC);
        push_byte(8'hA5);
        for (int k = 0; k < 4; k++) stim.push_back(1'($urandom_range(1)));
        for (int i = 0; i < stim.size(); i++) drive_bit(stim[i]);
        checks++;
        if (active !== 1'b1 || data_out !== 8'hA5) begin
            failures++;
            $display("FAIL midbyte_prelock active=%b data=%h exp active=1 data=a5", active, data_out);
        end
        do_reset();
        checks++;
        if ({active, byte_strobe, valid_out, data_out} !== 11'd0) begin
            failures++;
            $display("FAIL midbyte_reset_l4 got=%h exp=000", {active, byte_strobe, valid_out, data_out});
        end
        checks++;
        if ({active1, byte_strobe1, valid_out1, data_out1} !== 11'd0) begin
            failures++;
            $display("FAIL midbyte_reset_l1 got=%h exp=000", {active1, byte_strobe1, valid_out1, data_out1});
        end
        stim.delete();
        for (int k = 0; k < 4; k++) push_byte(8'hBC);
        push_byte(8'h77);
        for (int i = 0; i < stim.size(); i++) begin
            drive_bit(stim[i]);
            checks++;
            if ({active, byte_strobe, valid_out, data_out} !== model(4)) begin
                failures++;
                $display("FAIL midbyte_relock_l4 bit=%0d got=%h exp=%h", i, {active, byte_strobe, valid_out, data_out}, model(4));
            end
        end
    endtask

    task automatic test_lock1();
        do_reset();
        stim.delete();
        push_byte(8'hBC);
        for (int i = 0; i < stim.size(); i++) drive_bit(stim[i]);
        checks++;
        if (active1 !== 1'b1 || active !== 1'b0 || valid_out1 !== 1'b0) begin
            failures++;
            $display("FAIL lock1_single_comma active1=%b active4=%b valid1=%b exp 1 0 0", active1, active, valid_out1);
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            stim.delete();
            for (int k = 0; k < int'($urandom_range(7)); k++) stim.push_back(1'($urandom_range(1)));
            for (int k = 0; k < 2; k++) push_byte(8'($urandom));
            for (int k = 0; k < 4; k++) push_byte(8'hBC);
            for (int k = 0; k < 12; k++) begin
                v = ($urandom_range(3) == 0) ? 8'hBC : 8'($urandom);
                push_byte(v);
            end
            for (int i = 0; i < stim.size(); i++) begin
                drive_bit(stim[i]);
                checks++;
                if ({active, byte_strobe, valid_out, data_out} !== model(4)) begin
                    failures++;
                    $display("FAIL random_l4 it=%0d bit=%0d got=%h exp=%h", it, i, {active, byte_strobe, valid_out, data_out}, model(4));
                end
                checks++;
                if ({active1, byte_strobe1, valid_out1, data_out1} !== model(1)) begin
                    failures++;
                    $display("FAIL random_l1 it=%0d bit=%0d got=%h exp=%h", it, i, {active1, byte_strobe1, valid_out1, data_out1}, model(1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_initial_lock();
        test_locked_data();
        test_align_abort();
        test_false_comma();
        test_midbyte_reset();
        test_lock1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
